cp0_exc_unit: RTL and testbench

//  CP0 register file plus exception prioritiser, directly upstream of the pipeline control unit.

---
 rtl/cp0_exc_unit_pkg.sv | 55 +++++
 rtl/cp0_exc_unit_if.sv | 33 +++
 rtl/cp0_exc_unit_timer.sv | 45 ++++
 rtl/cp0_exc_unit.sv | 117 +++++++++++
 tb/tb_cp0_exc_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exc_unit_pkg.sv
// CP0 register map, except_info encodings, ExcCode values and the
// raw exception flag layout shared by the CP0/exception slice.
package cp0_exc_unit_pkg;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    typedef enum logic [3:0] {
        INFO_NONE    = 4'h0,
        INFO_INT     = 4'h1,
        INFO_ADEL_IF = 4'h2,
        INFO_RI      = 4'h3,
        INFO_OV      = 4'h4,
        INFO_SYS     = 4'h5,
        INFO_BP      = 4'h6,
        INFO_ADEL_LD = 4'h7,
        INFO_ADES    = 4'h8,
        INFO_ERET    = 4'hE
    } exc_info_e;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic adel_ld;
        logic ades;
    } mem_exc_t;

    function automatic logic [4:0] exc_code(input exc_info_e info);
        case (info)
            INFO_ADEL_IF, INFO_ADEL_LD: exc_code = EXC_ADEL;
            INFO_ADES:                  exc_code = EXC_ADES;
            INFO_RI:                    exc_code = EXC_RI;
            INFO_OV:                    exc_code = EXC_OV;
            INFO_SYS:                   exc_code = EXC_SYS;
            INFO_BP:                    exc_code = EXC_BP;
            default:                    exc_code = EXC_INT;
        endcase
    endfunction
endpackage

// File: rtl/cp0_exc_unit_if.sv
// MEM-stage exception inputs, mfc0/mtc0 port and control-unit outputs of the CP0 unit.
interface cp0_exc_unit_if;
    import cp0_exc_unit_pkg::*;

    logic        mem_valid;
    logic        mem_stall;
    logic [31:0] mem_pc;
    logic        mem_in_ds;
    mem_exc_t    mem_exc;
    logic        mem_eret;
    logic [31:0] mem_bad_vaddr;
    logic [5:0]  hw_int;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    exc_info_e   except_info_o;
    logic [31:0] epc_o;
    logic        timer_int_o;

    modport master (
        output mem_valid, mem_stall, mem_pc, mem_in_ds, mem_exc, mem_eret, mem_bad_vaddr,
               hw_int, cp0_raddr, cp0_we, cp0_waddr, cp0_wdata,
        input  cp0_rdata, except_info_o, epc_o, timer_int_o
    );

    modport slave (
        input  mem_valid, mem_stall, mem_pc, mem_in_ds, mem_exc, mem_eret, mem_bad_vaddr,
               hw_int, cp0_raddr, cp0_we, cp0_waddr, cp0_wdata,
        output cp0_rdata, except_info_o, epc_o, timer_int_o
    );
endinterface

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer: prescaled Count, sticky TI on match after increment,
// cleared by a Compare write (which beats a same-cycle match).
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic        presc;
    logic        tick;
    logic [31:0] count_inc;

    assign tick      = (COUNT_DIV == 1) ? 1'b1 : presc;
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                presc <= 1'b0;
            end else begin
                presc <= (COUNT_DIV == 1) ? 1'b0 : ~presc;
                if (tick) begin
                    count <= count_inc;
                    if (count_inc == compare) ti <= 1'b1;
                end
            end
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file plus exception prioritiser for the MEM-stage instruction;
// cause/EPC go to the control unit combinationally, state commits on the edge.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_unit_if.slave bus
);
    logic [7:0]  im;
    logic        exl, ie, bd;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code_q;
    logic [31:0] epc, bad_vaddr, count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic        int_pend, commit;
    exc_info_e   info;
    logic        we_status, we_cause, we_epc, we_count, we_compare;
    mem_exc_t    ex;

    assign ex         = bus.mem_exc;
    assign we_status  = bus.cp0_we && (bus.cp0_waddr == CP0_STATUS);
    assign we_cause   = bus.cp0_we && (bus.cp0_waddr == CP0_CAUSE);
    assign we_epc     = bus.cp0_we && (bus.cp0_waddr == CP0_EPC);
    assign we_count   = bus.cp0_we && (bus.cp0_waddr == CP0_COUNT);
    assign we_compare = bus.cp0_we && (bus.cp0_waddr == CP0_COMPARE);

    // Hardware IP bits are live, not latched; TI shares line 5 with hw_int[5].
    assign ip       = {ti | bus.hw_int[5], bus.hw_int[4:0], ip_sw};
    assign int_pend = ie & ~exl & (|(ip & im));

    always_comb begin
        info = INFO_NONE;
        if (bus.mem_valid) begin
            if      (int_pend)   info = INFO_INT;
            else if (ex.adel_if) info = INFO_ADEL_IF;
            else if (ex.ri)      info = INFO_RI;
            else if (ex.ov)      info = INFO_OV;
            else if (ex.sys)     info = INFO_SYS;
            else if (ex.bp)      info = INFO_BP;
            else if (ex.adel_ld) info = INFO_ADEL_LD;
            else if (ex.ades)    info = INFO_ADES;
            else if (bus.mem_eret) info = INFO_ERET;
        end
    end

    assign commit = bus.mem_valid & ~bus.mem_stall & (info != INFO_NONE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we_count),
        .compare_we (we_compare),
        .wdata      (bus.cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // mtc0 assignments come first so a same-cycle commit overrides them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ip_sw      <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            bad_vaddr  <= '0;
        end else begin
            if (we_status) begin
                im  <= bus.cp0_wdata[15:8];
                exl <= bus.cp0_wdata[1];
                ie  <= bus.cp0_wdata[0];
            end
            if (we_cause) ip_sw <= bus.cp0_wdata[9:8];
            if (we_epc)   epc   <= bus.cp0_wdata;
            if (commit) begin
                if (info == INFO_ERET) begin
                    exl <= 1'b0;
                end else begin
                    if (!exl) begin
                        epc <= bus.mem_in_ds ? bus.mem_pc - 32'd4 : bus.mem_pc;
                        bd  <= bus.mem_in_ds;
                    end
                    exl        <= 1'b1;
                    exc_code_q <= exc_code(info);
                    if (info == INFO_ADEL_IF)
                        bad_vaddr <= bus.mem_pc;
                    else if (info == INFO_ADEL_LD || info == INFO_ADES)
                        bad_vaddr <= bus.mem_bad_vaddr;
                end
            end
        end
    end

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_raddr)
            CP0_BADVADDR: bus.cp0_rdata = bad_vaddr;
            CP0_COUNT:    bus.cp0_rdata = count;
            CP0_COMPARE:  bus.cp0_rdata = compare;
            CP0_STATUS:   bus.cp0_rdata = STATUS_RST | {16'h0, im, 6'h0, exl, ie};
            CP0_CAUSE:    bus.cp0_rdata = {bd, ti, 14'h0, ip, 1'b0, exc_code_q, 2'b00};
            CP0_EPC:      bus.cp0_rdata = epc;
            default:      bus.cp0_rdata = '0;
        endcase
    end

    assign bus.except_info_o = info;
    assign bus.epc_o         = we_epc ? bus.cp0_wdata : epc;
    assign bus.timer_int_o   = ti;
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: hand-computed vectors per feature.
module tb_cp0_exc_unit;
    import cp0_exc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_exc_unit_if bus ();
    cp0_exc_unit #(.COUNT_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] d;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] dv);
        bus.cp0_raddr = a;
        #1;
        dv = bus.cp0_rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        bus.cp0_we = 1'b1; bus.cp0_waddr = a; bus.cp0_wdata = v;
        cyc();
        bus.cp0_we = 1'b0;
    endtask

    task automatic mem(input logic v, input logic st, input logic [31:0] pc, input logic ds,
                       input logic [6:0] exc, input logic er, input logic [31:0] bva);
        bus.mem_valid = v; bus.mem_stall = st; bus.mem_pc = pc; bus.mem_in_ds = ds;
        bus.mem_exc = exc; bus.mem_eret = er; bus.mem_bad_vaddr = bva;
    endtask

    task automatic idle();
        mem(1'b0, 1'b0, 32'h0, 1'b0, 7'h0, 1'b0, 32'h0);
    endtask

    task automatic eret();
        mem(1'b1, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1, 32'h0);
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_0000) begin n_bad++; $display("FAIL rst_status got %h want %h", d, 32'h0040_0000); end
        rd(CP0_COUNT, d); n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL rst_count got %h want 0", d); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL rst_cause got %h want 0", d); end
        n_cmp++;
        if (bus.except_info_o !== 4'h0) begin n_bad++; $display("FAIL rst_info got %h want 0", bus.except_info_o); end
        n_cmp++;
        if (bus.epc_o !== 32'h0 || bus.timer_int_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_epc_ti got %h/%b want 0/0", bus.epc_o, bus.timer_int_o);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_ov();
        mem(1'b1, 1'b0, 32'hBFC0_0100, 1'b0, 7'b0010000, 1'b0, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h4) begin n_bad++; $display("FAIL ov_info got %h want 4", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'hBFC0_0100) begin n_bad++; $display("FAIL ov_epc got %h want %h", d, 32'hBFC0_0100); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0030) begin n_bad++; $display("FAIL ov_cause got %h want %h", d, 32'h30); end
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_0002) begin n_bad++; $display("FAIL ov_status got %h want %h", d, 32'h0040_0002); end
        mem(1'b1, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'hE) begin n_bad++; $display("FAIL eret_info got %h want e", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_0000) begin n_bad++; $display("FAIL eret_status got %h want %h", d, 32'h0040_0000); end
    endtask

    task automatic test_sys_ds();
        mem(1'b1, 1'b0, 32'hBFC0_0204, 1'b1, 7'b0001000, 1'b0, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h5) begin n_bad++; $display("FAIL sys_info got %h want 5", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'hBFC0_0200) begin n_bad++; $display("FAIL sys_epc got %h want %h", d, 32'hBFC0_0200); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h8000_0020) begin n_bad++; $display("FAIL sys_cause got %h want %h", d, 32'h8000_0020); end
        mem(1'b1, 1'b0, 32'hBFC0_0300, 1'b0, 7'b0000100, 1'b0, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h6) begin n_bad++; $display("FAIL bp_info got %h want 6", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'hBFC0_0200) begin n_bad++; $display("FAIL nested_epc got %h want %h", d, 32'hBFC0_0200); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h8000_0024) begin n_bad++; $display("FAIL nested_cause got %h want %h", d, 32'h8000_0024); end
    endtask

    task automatic test_eret_bypass();
        bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h8000_1000;
        mem(1'b1, 1'b0, 32'h0, 1'b0, 7'h0, 1'b1, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'hE || bus.epc_o !== 32'h8000_1000) begin
            n_bad++; $display("FAIL bypass_out got %h/%h want e/%h", bus.except_info_o, bus.epc_o, 32'h8000_1000);
        end
        cyc(); bus.cp0_we = 1'b0; idle();
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_0000) begin n_bad++; $display("FAIL bypass_status got %h want %h", d, 32'h0040_0000); end
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'h8000_1000) begin n_bad++; $display("FAIL bypass_epc got %h want %h", d, 32'h8000_1000); end
    endtask

    task automatic test_commit_wins();
        bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h1234_5678;
        mem(1'b1, 1'b0, 32'hBFC0_0400, 1'b0, 7'b0010000, 1'b0, 32'h0);
        cyc(); bus.cp0_we = 1'b0; idle();
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'hBFC0_0400) begin n_bad++; $display("FAIL win_epc got %h want %h", d, 32'hBFC0_0400); end
        // EXL=1: commit leaves EPC alone so the mtc0 lands
        bus.cp0_we = 1'b1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h1234_5678;
        mem(1'b1, 1'b0, 32'hBFC0_0500, 1'b0, 7'b0001000, 1'b0, 32'h0);
        cyc(); bus.cp0_we = 1'b0; idle();
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL exl_mtc0_epc got %h want %h", d, 32'h1234_5678); end
        eret();
    endtask

    task automatic test_regs();
        wr(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, d); n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped got %h want 0", d); end
        wr(CP0_CAUSE, 32'hFFFF_FFFF);
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0320) begin n_bad++; $display("FAIL cause_wr got %h want %h", d, 32'h320); end
        wr(CP0_CAUSE, 32'h0);
        wr(CP0_STATUS, 32'hFFFF_FFFF);
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_FF03) begin n_bad++; $display("FAIL status_wr got %h want %h", d, 32'h0040_FF03); end
        wr(CP0_STATUS, 32'h0000_0101);
        wr(CP0_CAUSE, 32'h0000_0100);
        mem(1'b1, 1'b0, 32'hBFC0_0580, 1'b0, 7'b1000000, 1'b0, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h1) begin n_bad++; $display("FAIL swint_info got %h want 1", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL swint_cause got %h want %h", d, 32'h100); end
        wr(CP0_CAUSE, 32'h0);
        bus.hw_int = 6'b000100;
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_1000) begin n_bad++; $display("FAIL hwint_cause got %h want %h", d, 32'h1000); end
        bus.hw_int = 6'h0;
        eret();
    endtask

    task automatic test_timer();
        wr(CP0_STATUS, 32'h0000_8001);
        wr(CP0_COMPARE, 32'd10);
        wr(CP0_COUNT, 32'd0);
        repeat (19) cyc();
        n_cmp++;
        if (bus.timer_int_o !== 1'b0) begin n_bad++; $display("FAIL ti_early got %b want 0", bus.timer_int_o); end
        cyc(); n_cmp++;
        if (bus.timer_int_o !== 1'b1) begin n_bad++; $display("FAIL ti_set got %b want 1", bus.timer_int_o); end
        rd(CP0_COUNT, d); n_cmp++;
        if (d !== 32'd10) begin n_bad++; $display("FAIL ti_count got %h want %h", d, 32'd10); end
        mem(1'b1, 1'b0, 32'hBFC0_0600, 1'b0, 7'h0, 1'b0, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h1) begin n_bad++; $display("FAIL tint_info got %h want 1", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h4000_8000) begin n_bad++; $display("FAIL tint_cause got %h want %h", d, 32'h4000_8000); end
        mem(1'b1, 1'b0, 32'hBFC0_0604, 1'b0, 7'h0, 1'b0, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h0) begin n_bad++; $display("FAIL exl_mask got %h want 0", bus.except_info_o); end
        idle();
        wr(CP0_COMPARE, 32'hFFFF_FFFF);
        n_cmp++;
        if (bus.timer_int_o !== 1'b0) begin n_bad++; $display("FAIL ti_clear got %b want 0", bus.timer_int_o); end
        eret();
    endtask

    task automatic test_prio_stall();
        mem(1'b1, 1'b0, 32'hBFC0_0300, 1'b0, 7'b0100010, 1'b0, 32'hDEAD_0000);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h3) begin n_bad++; $display("FAIL prio_info got %h want 3", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_BADVADDR, d); n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL prio_bva got %h want 0", d); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0028) begin n_bad++; $display("FAIL prio_cause got %h want %h", d, 32'h28); end
        mem(1'b1, 1'b1, 32'hBFC0_0700, 1'b1, 7'b0100010, 1'b0, 32'h1234);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h3) begin n_bad++; $display("FAIL stall_info got %h want 3", bus.except_info_o); end
        cyc(); cyc(); idle();
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'hBFC0_0300) begin n_bad++; $display("FAIL stall_epc got %h want %h", d, 32'hBFC0_0300); end
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_8003) begin n_bad++; $display("FAIL stall_status got %h want %h", d, 32'h0040_8003); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0028) begin n_bad++; $display("FAIL stall_cause got %h want %h", d, 32'h28); end
        mem(1'b0, 1'b0, 32'hBFC0_0700, 1'b0, 7'h7F, 1'b1, 32'h0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h0) begin n_bad++; $display("FAIL bubble_info got %h want 0", bus.except_info_o); end
        idle();
        eret();
    endtask

    task automatic test_badvaddr();
        mem(1'b1, 1'b0, 32'hBFC0_0800, 1'b0, 7'b0000010, 1'b0, 32'hDEAD_BEE0);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h7) begin n_bad++; $display("FAIL adel_info got %h want 7", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_BADVADDR, d); n_cmp++;
        if (d !== 32'hDEAD_BEE0) begin n_bad++; $display("FAIL adel_bva got %h want %h", d, 32'hDEAD_BEE0); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0010) begin n_bad++; $display("FAIL adel_cause got %h want %h", d, 32'h10); end
        eret();
        mem(1'b1, 1'b0, 32'hBFC0_0810, 1'b0, 7'b0000001, 1'b0, 32'h0000_0103);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h8) begin n_bad++; $display("FAIL ades_info got %h want 8", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_BADVADDR, d); n_cmp++;
        if (d !== 32'h0000_0103) begin n_bad++; $display("FAIL ades_bva got %h want %h", d, 32'h103); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h0000_0014) begin n_bad++; $display("FAIL ades_cause got %h want %h", d, 32'h14); end
        eret();
        mem(1'b1, 1'b0, 32'hBFC0_0901, 1'b1, 7'h7F, 1'b1, 32'h5555_5555);
        #1; n_cmp++;
        if (bus.except_info_o !== 4'h2) begin n_bad++; $display("FAIL adelif_info got %h want 2", bus.except_info_o); end
        cyc(); idle();
        rd(CP0_BADVADDR, d); n_cmp++;
        if (d !== 32'hBFC0_0901) begin n_bad++; $display("FAIL adelif_bva got %h want %h", d, 32'hBFC0_0901); end
        rd(CP0_EPC, d); n_cmp++;
        if (d !== 32'hBFC0_08FD) begin n_bad++; $display("FAIL adelif_epc got %h want %h", d, 32'hBFC0_08FD); end
        rd(CP0_CAUSE, d); n_cmp++;
        if (d !== 32'h8000_0010) begin n_bad++; $display("FAIL adelif_cause got %h want %h", d, 32'h8000_0010); end
    endtask

    task automatic test_reset_mid();
        mem(1'b1, 1'b0, 32'hBFC0_0A00, 1'b0, 7'b0010000, 1'b0, 32'h0);
        #1;
        rst = 1'b1;
        rd(CP0_STATUS, d); n_cmp++;
        if (d !== 32'h0040_0000) begin n_bad++; $display("FAIL midrst_status got %h want %h", d, 32'h0040_0000); end
        n_cmp++;
        if (bus.epc_o !== 32'h0) begin n_bad++; $display("FAIL midrst_epc got %h want 0", bus.epc_o); end
        cyc();
        rd(CP0_BADVADDR, d); n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL midrst_bva got %h want 0", d); end
        idle();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.hw_int = 6'h0; bus.cp0_raddr = 5'h0;
        bus.cp0_we = 1'b0; bus.cp0_waddr = 5'h0; bus.cp0_wdata = 32'h0;
        test_reset();
        test_ov();
        test_sys_ds();
        test_eret_bypass();
        test_commit_wins();
        test_regs();
        test_timer();
        test_prio_stall();
        test_badvaddr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
